// File: rtl/freqchng_ctrl.sv
// Sequencer for the two-stage BUFGMUX frequency select: moves one mux stage
// per step and holds a settle interval after each change.
module freqchng_ctrl #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    input  logic [2:0] REQ_IDX,
    output logic       REQ_READY,
    output logic [2:0] FREQ_SEL,
    output logic [1:0] CUR_IDX,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    // STEP0/STEP1 writes are folded into the transitions that enter WAIT0/WAIT1,
    // so the first select change is visible the cycle after acceptance.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_tgt;
    logic [1:0]      r_cur;
    logic            r_err;

    state_t          w_nxt_state;
    logic [1:0]      w_nxt_sel;
    logic [CW-1:0]   w_nxt_cnt;
    logic [1:0]      w_nxt_tgt;
    logic [1:0]      w_nxt_cur;
    logic            w_nxt_err;

    logic            w_ready;
    logic            w_accept;
    logic            w_legal;
    logic            w_req_sel0;
    logic            w_req_sel1;
    logic            w_tgt_sel1;

    assign w_ready    = (r_state == IDLE) || (r_state == FIN);
    assign w_accept   = REQ_VALID && w_ready;
    assign w_legal    = (REQ_IDX <= 3'd2);
    assign w_req_sel1 = (REQ_IDX[1:0] == 2'd2);
    // idx2 hides stage 0 behind stage 1, so its stage-0 bit is left alone.
    assign w_req_sel0 = w_req_sel1 ? r_sel[0] : REQ_IDX[0];
    assign w_tgt_sel1 = (r_tgt == 2'd2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_sel   <= 2'b00;
            r_cnt   <= '0;
            r_tgt   <= 2'd0;
            r_cur   <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_cnt   <= w_nxt_cnt;
            r_tgt   <= w_nxt_tgt;
            r_cur   <= w_nxt_cur;
            r_err   <= w_nxt_err;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_cnt   = r_cnt;
        w_nxt_tgt   = r_tgt;
        w_nxt_cur   = r_cur;
        w_nxt_err   = 1'b0;
        case (r_state)
            IDLE, FIN: begin
                w_nxt_state = IDLE;
                if (w_accept) begin
                    if (!w_legal) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_nxt_tgt = REQ_IDX[1:0];
                        if (w_req_sel0 != r_sel[0]) begin
                            w_nxt_sel[0] = w_req_sel0;
                            w_nxt_cnt    = CNT_LOAD;
                            w_nxt_state  = WAIT0;
                        end else if (w_req_sel1 != r_sel[1]) begin
                            w_nxt_sel[1] = w_req_sel1;
                            w_nxt_cnt    = CNT_LOAD;
                            w_nxt_state  = WAIT1;
                        end else begin
                            w_nxt_cur   = REQ_IDX[1:0];
                            w_nxt_state = FIN;
                        end
                    end
                end
            end
            WAIT0: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CW'(1);
                end else if (w_tgt_sel1 != r_sel[1]) begin
                    w_nxt_sel[1] = w_tgt_sel1;
                    w_nxt_cnt    = CNT_LOAD;
                    w_nxt_state  = WAIT1;
                end else begin
                    w_nxt_cur   = r_tgt;
                    w_nxt_state = FIN;
                end
            end
            WAIT1: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CW'(1);
                end else begin
                    w_nxt_cur   = r_tgt;
                    w_nxt_state = FIN;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    assign REQ_READY = w_ready;
    assign FREQ_SEL  = {1'b0, r_sel};
    assign CUR_IDX   = r_cur;
    assign BUSY      = (r_state == WAIT0) || (r_state == WAIT1);
    assign DONE      = (r_state == FIN);
    assign ERR       = r_err;

endmodule
